// File: rtl/rot_outbuf_reader_if.sv
// Buffer-read and DMA-write signal bundle between the output-buffer reader and its neighbours.
// The master side is the reader: it drives the buffer address and the DMA word and samples RDATA/WREADY.
interface rot_outbuf_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              O_BUF_REN;
    logic [ADDR_W-1:0] O_BUF_RADDR;
    logic [7:0]        I_BUF_RDATA;
    logic              O_DMA_WVALID;
    logic [DATA_W-1:0] O_DMA_WDATA;
    logic              I_DMA_WREADY;

    modport master (
        output O_BUF_REN,
        output O_BUF_RADDR,
        input  I_BUF_RDATA,
        output O_DMA_WVALID,
        output O_DMA_WDATA,
        input  I_DMA_WREADY
    );

    modport slave (
        input  O_BUF_REN,
        input  O_BUF_RADDR,
        output I_BUF_RDATA,
        input  O_DMA_WVALID,
        input  O_DMA_WDATA,
        output I_DMA_WREADY
    );
endinterface

// File: rtl/rot_outbuf_reader.sv
// Drains one rotated tile from the byte-wide output buffer as 32-bit DMA words, ascending byte order.
// 6 cycles per word with WREADY high (4 reads, 1 capture, 1 send); WVALID holds with stable WDATA until WREADY.
module rot_outbuf_reader #(
    parameter int TILE_BYTES = 192,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32
) (
    input  logic                 I_HCLK,
    input  logic                 I_HRESET,
    input  logic                 I_TILE_DONE,
    output logic                 O_TILE_BUSY,
    output logic                 O_TILE_ACK,
    output logic                 O_OVERRUN,
    rot_outbuf_reader_if.master  bus
);

    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(TILE_BYTES - 4);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_SEND,
        S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_idx;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_raddr_hold;
    logic [7:0]          r_lane0;
    logic [7:0]          r_lane1;
    logic [7:0]          r_lane2;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_ovr;

    logic                w_start;
    logic                w_busy;
    logic                w_ren;
    logic                w_wvalid;
    logic                w_ack;
    logic                w_next_word;
    logic [ADDR_W-1:0]   w_raddr;

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_busy      = 1'b0;
        w_ren       = 1'b0;
        w_wvalid    = 1'b0;
        w_ack       = 1'b0;
        w_next_word = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_TILE_DONE) begin
                    w_next  = S_READ;
                    w_start = 1'b1;
                end
            end
            S_READ: begin
                w_busy = 1'b1;
                w_ren  = 1'b1;
                if (r_idx == 2'd3) begin
                    w_next = S_CAPT;
                end
            end
            S_CAPT: begin
                w_busy = 1'b1;
                w_next = S_SEND;
            end
            S_SEND: begin
                w_busy   = 1'b1;
                w_wvalid = 1'b1;
                if (bus.I_DMA_WREADY) begin
                    if (r_base == LAST_BASE) begin
                        w_next = S_ACK;
                    end else begin
                        w_next      = S_READ;
                        w_next_word = 1'b1;
                    end
                end
            end
            S_ACK: begin
                w_ack = 1'b1;
                // A new tile may start straight out of ACK without an idle bubble.
                if (I_TILE_DONE) begin
                    w_next  = S_READ;
                    w_start = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_raddr = (r_state == S_READ) ? (r_base + ADDR_W'(r_idx)) : r_raddr_hold;

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            r_idx        <= 2'd0;
            r_base       <= '0;
            r_raddr_hold <= '0;
            r_lane0      <= 8'd0;
            r_lane1      <= 8'd0;
            r_lane2      <= 8'd0;
            r_wdata      <= '0;
            r_ovr        <= 1'b0;
        end else begin
            r_raddr_hold <= w_raddr;

            if (w_start) begin
                r_base <= '0;
                r_idx  <= 2'd0;
            end else if (r_state == S_READ) begin
                r_idx <= r_idx + 2'd1;
            end else if (w_next_word) begin
                r_base <= r_base + WORD_STEP;
                r_idx  <= 2'd0;
            end

            // RDATA trails REN by one cycle, so READ cycle i lands the byte of address i-1.
            if (r_state == S_READ) begin
                case (r_idx)
                    2'd1:    r_lane0 <= bus.I_BUF_RDATA;
                    2'd2:    r_lane1 <= bus.I_BUF_RDATA;
                    2'd3:    r_lane2 <= bus.I_BUF_RDATA;
                    default: ;
                endcase
            end

            if (r_state == S_CAPT) begin
                r_wdata <= {bus.I_BUF_RDATA, r_lane2, r_lane1, r_lane0};
            end

            if (I_TILE_DONE && w_busy) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign bus.O_BUF_REN    = w_ren;
    assign bus.O_BUF_RADDR  = w_raddr;
    assign bus.O_DMA_WVALID = w_wvalid;
    assign bus.O_DMA_WDATA  = r_wdata;
    assign O_TILE_BUSY      = w_busy;
    assign O_TILE_ACK       = w_ack;
    assign O_OVERRUN        = r_ovr;

endmodule

// File: tb/tb_rot_outbuf_reader.sv
// Directed bench for rot_outbuf_reader: buffer model returns addr^seed one cycle after REN.
module tb_rot_outbuf_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic done;
    logic busy;
    logic ack;
    logic ovr;
    logic [7:0] seed;

    rot_outbuf_reader_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    rot_outbuf_reader #(.TILE_BYTES(192), .ADDR_W(8), .DATA_W(32)) dut (
        .I_HCLK      (clk),
        .I_HRESET    (rst),
        .I_TILE_DONE (done),
        .O_TILE_BUSY (busy),
        .O_TILE_ACK  (ack),
        .O_OVERRUN   (ovr),
        .bus         (bus)
    );

    always @(posedge clk) begin
        if (bus.O_BUF_REN) bus.I_BUF_RDATA <= bus.O_BUF_RADDR ^ seed;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    int          t0 = 0;
    logic [31:0] wq[$];
    int          wrel[$];
    int          ack_cnt = 0;
    int          ack_rel = 0;
    int          busy_cnt = 0;
    int          stab_err = 0;
    int          ren_in_send = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;

    always @(negedge clk) begin
        if (prev_stall && (!bus.O_DMA_WVALID || bus.O_DMA_WDATA !== prev_dat)) stab_err++;
        prev_stall = bus.O_DMA_WVALID && !bus.I_DMA_WREADY;
        prev_dat   = bus.O_DMA_WDATA;
        if (bus.O_DMA_WVALID && bus.I_DMA_WREADY) begin
            wq.push_back(bus.O_DMA_WDATA);
            wrel.push_back(cyc + 1 - t0);
        end
        if (ack) begin
            ack_cnt++;
            ack_rel = cyc + 1 - t0;
        end
        if (busy) busy_cnt++;
        if (bus.O_DMA_WVALID && bus.O_BUF_REN) ren_in_send++;
    end

    task automatic clear_mon();
        wq.delete();
        wrel.delete();
        ack_cnt     = 0;
        busy_cnt    = 0;
        stab_err    = 0;
        ren_in_send = 0;
        prev_stall  = 1'b0;
    endtask

    // Called at #1 after an edge; returns one cycle into the tile with t0 = the edge that sampled done.
    task automatic start_tile();
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        t0 = cyc;
    endtask

    // mode 0: WREADY=1; mode 1: stall word 2 for 5 cycles; mode 2: random WREADY.
    task automatic run_tile(input int target, input int mode, output bit to);
        int stall = 0;
        to = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (mode == 1) begin
                if (bus.O_DMA_WVALID && wq.size() == 2 && stall < 5) begin
                    bus.I_DMA_WREADY = 1'b0;
                    stall++;
                end else begin
                    bus.I_DMA_WREADY = 1'b1;
                end
            end else if (mode == 2) begin
                bus.I_DMA_WREADY = 1'($urandom_range(0, 1));
            end else begin
                bus.I_DMA_WREADY = 1'b1;
            end
            if (ack_cnt >= target) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bit got_vld = 1'b0;
        rst = 1'b1; done = 1'b0; seed = 8'd0; bus.I_DMA_WREADY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.O_DMA_WVALID !== 1'b0) begin bad++; $display("FAIL rst_wvalid got=%b want=0", bus.O_DMA_WVALID); end
        total++; if (bus.O_BUF_REN !== 1'b0) begin bad++; $display("FAIL rst_ren got=%b want=0", bus.O_BUF_REN); end
        total++; if (busy !== 1'b0 || ack !== 1'b0 || ovr !== 1'b0) begin bad++; $display("FAIL rst_flags got busy=%b ack=%b ovr=%b want 000", busy, ack, ovr); end
        total++; if (bus.O_DMA_WDATA !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", bus.O_DMA_WDATA); end
        rst = 1'b0;
        clear_mon();
        start_tile();
        for (int i = 0; i < 20; i++) begin
            if (bus.O_DMA_WVALID) begin got_vld = 1'b1; break; end
            @(posedge clk); #1;
        end
        total++; if (got_vld !== 1'b1) begin bad++; $display("FAIL rst_reach_send got=%b want=1", got_vld); end
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        total++; if (bus.O_DMA_WVALID !== 1'b0 || bus.O_BUF_REN !== 1'b0) begin bad++; $display("FAIL midsend_rst_vld_ren got=%b%b want=00", bus.O_DMA_WVALID, bus.O_BUF_REN); end
        total++; if (busy !== 1'b0 || ack !== 1'b0 || ovr !== 1'b0) begin bad++; $display("FAIL midsend_rst_flags got=%b%b%b want=000", busy, ack, ovr); end
        total++; if (bus.O_DMA_WDATA !== 32'h0) begin bad++; $display("FAIL midsend_rst_wdata got=%h want=0", bus.O_DMA_WDATA); end
        rst = 1'b1; done = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_wins_busy got=%b want=0", busy); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || bus.O_BUF_REN !== 1'b0) begin bad++; $display("FAIL rst_wins_idle got busy=%b ren=%b want 00", busy, bus.O_BUF_REN); end
    endtask

    task automatic test_full_tile();
        bit to;
        clear_mon();
        bus.I_DMA_WREADY = 1'b1;
        start_tile();
        total++; if (bus.O_BUF_REN !== 1'b1 || bus.O_BUF_RADDR !== 8'd0) begin bad++; $display("FAIL full_first_read got ren=%b addr=%0d want ren=1 addr=0", bus.O_BUF_REN, bus.O_BUF_RADDR); end
        run_tile(1, 0, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL full_timeout got=%b want=0", to); end
        total++; if (wq.size() !== 48) begin bad++; $display("FAIL full_words got=%0d want=48", wq.size()); end
        if (wq.size() >= 48) begin
            total++; if (wq[0] !== 32'h03020100 || wrel[0] !== 6) begin bad++; $display("FAIL full_word0 got=%h@%0d want=03020100@6", wq[0], wrel[0]); end
            total++; if (wq[47] !== 32'hBFBEBDBC || wrel[47] !== 288) begin bad++; $display("FAIL full_word47 got=%h@%0d want=bfbebdbc@288", wq[47], wrel[47]); end
        end
        total++; if (ack_cnt !== 1 || ack_rel !== 289) begin bad++; $display("FAIL full_ack got cnt=%0d at=%0d want cnt=1 at=289", ack_cnt, ack_rel); end
        total++; if (busy_cnt !== 288) begin bad++; $display("FAIL full_busy_cycles got=%0d want=288", busy_cnt); end
    endtask

    task automatic test_backpressure();
        bit to;
        clear_mon();
        start_tile();
        run_tile(1, 1, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout got=%b want=0", to); end
        total++; if (wq.size() !== 48) begin bad++; $display("FAIL bp_words got=%0d want=48", wq.size()); end
        if (wq.size() >= 48) begin
            total++; if (wq[2] !== 32'h0B0A0908 || wrel[2] !== 23) begin bad++; $display("FAIL bp_word2 got=%h@%0d want=0b0a0908@23", wq[2], wrel[2]); end
            total++; if (wrel[47] !== 293) begin bad++; $display("FAIL bp_last_time got=%0d want=293", wrel[47]); end
        end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stab_err); end
        total++; if (ren_in_send !== 0) begin bad++; $display("FAIL bp_ren_during_send got=%0d want=0", ren_in_send); end
        total++; if (ack_cnt !== 1) begin bad++; $display("FAIL bp_acks got=%0d want=1", ack_cnt); end
    endtask

    task automatic test_overrun();
        bit to;
        clear_mon();
        bus.I_DMA_WREADY = 1'b1;
        start_tile();
        repeat (49) @(posedge clk);
        #1;
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_before got=%b want=0", ovr); end
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", ovr); end
        run_tile(1, 0, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL ovr_timeout got=%b want=0", to); end
        total++; if (wq.size() !== 48 || ack_cnt !== 1) begin bad++; $display("FAIL ovr_tile got words=%0d acks=%0d want 48/1", wq.size(), ack_cnt); end
        if (wq.size() >= 48) begin
            total++; if (wrel[47] !== 288) begin bad++; $display("FAIL ovr_last_time got=%0d want=288", wrel[47]); end
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", ovr); end
    endtask

    task automatic test_back_to_back();
        bit to;
        bit seen_ack = 1'b0;
        clear_mon();
        bus.I_DMA_WREADY = 1'b1;
        start_tile();
        for (int i = 0; i < 400; i++) begin
            if (ack) begin seen_ack = 1'b1; break; end
            @(posedge clk); #1;
        end
        total++; if (seen_ack !== 1'b1) begin bad++; $display("FAIL b2b_first_ack got=%b want=1", seen_ack); end
        start_tile();
        total++; if (bus.O_BUF_REN !== 1'b1 || bus.O_BUF_RADDR !== 8'd0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_restart got ren=%b addr=%0d busy=%b want 1/0/1", bus.O_BUF_REN, bus.O_BUF_RADDR, busy); end
        run_tile(2, 0, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL b2b_timeout got=%b want=0", to); end
        total++; if (wq.size() !== 96 || ack_cnt !== 2) begin bad++; $display("FAIL b2b_counts got words=%0d acks=%0d want 96/2", wq.size(), ack_cnt); end
        if (wq.size() >= 96) begin
            total++; if (wq[48] !== 32'h03020100 || wrel[48] !== 6) begin bad++; $display("FAIL b2b_second_first got=%h@%0d want=03020100@6", wq[48], wrel[48]); end
        end
    endtask

    task automatic test_random();
        bit   to;
        int   words = 0;
        int   mism = 0;
        int   stab = 0;
        int   acks = 0;
        int   tos = 0;
        logic [31:0] exp;
        for (int k = 0; k < 20; k++) begin
            seed = 8'((k * 37) + 1);
            clear_mon();
            start_tile();
            run_tile(1, 2, to);
            if (to) tos++;
            for (int j = 0; j < wq.size(); j++) begin
                for (int b = 0; b < 4; b++) exp[8*b +: 8] = 8'(4*j + b) ^ seed;
                if (j >= 48 || wq[j] !== exp) mism++;
            end
            words += wq.size();
            stab  += stab_err;
            acks  += ack_cnt;
        end
        total++; if (tos !== 0) begin bad++; $display("FAIL rnd_timeouts got=%0d want=0", tos); end
        total++; if (words !== 960) begin bad++; $display("FAIL rnd_words got=%0d want=960", words); end
        total++; if (mism !== 0) begin bad++; $display("FAIL rnd_data got=%0d bad words want=0", mism); end
        total++; if (stab !== 0) begin bad++; $display("FAIL rnd_stable got=%0d want=0", stab); end
        total++; if (acks !== 20) begin bad++; $display("FAIL rnd_acks got=%0d want=20", acks); end
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
